// File: rtl/vending_panel_arbiter_if.sv
// Signal bundle between the two user panels, the shared vending machine and the panel arbiter.
interface vending_panel_arbiter_if;
    logic [1:0] p0_coin;
    logic [1:0] p1_coin;
    logic [1:0] p0_item_sel;
    logic [1:0] p1_item_sel;
    logic       p0_cancel;
    logic       p1_cancel;
    logic [2:0] vm_state;
    logic [1:0] vm_dispense;
    logic [7:0] vm_change;
    logic       vm_error;
    logic [1:0] vm_coin;
    logic [1:0] vm_item_sel;
    logic       vm_cancel;
    logic [1:0] owner;
    logic       p0_reject;
    logic       p1_reject;
    logic       p0_done;
    logic       p1_done;
    logic [1:0] res_dispense;
    logic [7:0] res_change;
    logic       res_error;
    logic       timeout;

    modport slave (
        input  p0_coin, p1_coin, p0_item_sel, p1_item_sel, p0_cancel, p1_cancel,
        input  vm_state, vm_dispense, vm_change, vm_error,
        output vm_coin, vm_item_sel, vm_cancel, owner,
        output p0_reject, p1_reject, p0_done, p1_done,
        output res_dispense, res_change, res_error, timeout
    );

    modport master (
        output p0_coin, p1_coin, p0_item_sel, p1_item_sel, p0_cancel, p1_cancel,
        output vm_state, vm_dispense, vm_change, vm_error,
        input  vm_coin, vm_item_sel, vm_cancel, owner,
        input  p0_reject, p1_reject, p0_done, p1_done,
        input  res_dispense, res_change, res_error, timeout
    );
endinterface

// File: rtl/vending_panel_arbiter.sv
// Shares one vending machine between two panels: grants a session to one panel, forwards only
// its inputs, refuses the other's coins, records the session result and cancels idle sessions.
module vending_panel_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vending_panel_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        OWN      = 2'd1,
        FINISH   = 2'd2
    } arb_state_e;

    localparam logic [2:0]       VM_IDLE   = 3'b000;
    localparam logic [2:0]       VM_CHANGE = 3'b100;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vm_coin_q, vm_coin_d;
    logic [1:0]       vm_item_sel_q, vm_item_sel_d;
    logic             vm_cancel_q, vm_cancel_d;
    logic             p0_reject_q, p0_reject_d;
    logic             p1_reject_q, p1_reject_d;
    logic             p0_done_q, p0_done_d;
    logic             p1_done_q, p1_done_d;
    logic [1:0]       res_dispense_q, res_dispense_d;
    logic [7:0]       res_change_q, res_change_d;
    logic             res_error_q, res_error_d;
    logic             timeout_q, timeout_d;

    logic             own_is_p1;
    logic [1:0]       own_coin;
    logic [1:0]       own_item_sel;
    logic             own_cancel;
    logic [1:0]       other_coin;
    logic             own_active;
    logic             p0_req;
    logic             p1_req;

    // Route the current owner's inputs; ptr_q = 0 favours P0, 1 favours P1.
    assign own_is_p1    = owner_q[1];
    assign own_coin     = own_is_p1 ? bus.p1_coin     : bus.p0_coin;
    assign own_item_sel = own_is_p1 ? bus.p1_item_sel : bus.p0_item_sel;
    assign own_cancel   = own_is_p1 ? bus.p1_cancel   : bus.p0_cancel;
    assign other_coin   = own_is_p1 ? bus.p0_coin     : bus.p1_coin;
    assign own_active   = (own_coin != 2'b00) || (own_item_sel != 2'b00) || own_cancel;
    assign p0_req       = (bus.p0_coin != 2'b00);
    assign p1_req       = (bus.p1_coin != 2'b00);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        vm_coin_d      = 2'b00;
        vm_item_sel_d  = 2'b00;
        vm_cancel_d    = 1'b0;
        p0_reject_d    = 1'b0;
        p1_reject_d    = 1'b0;
        p0_done_d      = 1'b0;
        p1_done_d      = 1'b0;
        res_dispense_d = res_dispense_q;
        res_change_d   = res_change_q;
        res_error_d    = res_error_q;
        timeout_d      = timeout_q;

        if (state_q != ARB_IDLE) begin
            if (bus.vm_dispense != 2'b00) res_dispense_d = bus.vm_dispense;
            if (bus.vm_change != 8'd0)    res_change_d   = bus.vm_change;
            if (bus.vm_error)             res_error_d    = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (p0_req && (!p1_req || !ptr_q)) begin
                    owner_d     = 2'b01;
                    vm_coin_d   = bus.p0_coin;
                    p1_reject_d = p1_req;
                end else if (p1_req) begin
                    owner_d     = 2'b10;
                    vm_coin_d   = bus.p1_coin;
                    p0_reject_d = p0_req;
                end
                if (p0_req || p1_req) begin
                    res_dispense_d = 2'b00;
                    res_change_d   = 8'd0;
                    res_error_d    = 1'b0;
                    timeout_d      = 1'b0;
                    cnt_d          = '0;
                    state_d        = OWN;
                end
            end

            OWN: begin
                vm_coin_d     = own_coin;
                vm_item_sel_d = own_item_sel;
                vm_cancel_d   = own_cancel;
                if (own_is_p1) p0_reject_d = (other_coin != 2'b00);
                else           p1_reject_d = (other_coin != 2'b00);
                cnt_d = own_active ? '0 : cnt_q + CNT_W'(1);
                // An idle owner forfeits the session; the forced cancel makes the machine refund.
                if (!own_active && (cnt_q == CNT_LAST)) begin
                    vm_cancel_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = FINISH;
                end else if (bus.vm_state == VM_CHANGE) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                p0_reject_d = p0_req;
                p1_reject_d = p1_req;
                if (bus.vm_state == VM_IDLE) begin
                    p0_done_d = owner_q[0];
                    p1_done_d = owner_q[1];
                    ptr_d     = owner_q[0];
                    owner_d   = 2'b00;
                    state_d   = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                owner_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            owner_q        <= 2'b00;
            ptr_q          <= 1'b0;
            cnt_q          <= '0;
            vm_coin_q      <= 2'b00;
            vm_item_sel_q  <= 2'b00;
            vm_cancel_q    <= 1'b0;
            p0_reject_q    <= 1'b0;
            p1_reject_q    <= 1'b0;
            p0_done_q      <= 1'b0;
            p1_done_q      <= 1'b0;
            res_dispense_q <= 2'b00;
            res_change_q   <= 8'd0;
            res_error_q    <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            vm_coin_q      <= vm_coin_d;
            vm_item_sel_q  <= vm_item_sel_d;
            vm_cancel_q    <= vm_cancel_d;
            p0_reject_q    <= p0_reject_d;
            p1_reject_q    <= p1_reject_d;
            p0_done_q      <= p0_done_d;
            p1_done_q      <= p1_done_d;
            res_dispense_q <= res_dispense_d;
            res_change_q   <= res_change_d;
            res_error_q    <= res_error_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.vm_coin      = vm_coin_q;
    assign bus.vm_item_sel  = vm_item_sel_q;
    assign bus.vm_cancel    = vm_cancel_q;
    assign bus.owner        = owner_q;
    assign bus.p0_reject    = p0_reject_q;
    assign bus.p1_reject    = p1_reject_q;
    assign bus.p0_done      = p0_done_q;
    assign bus.p1_done      = p1_done_q;
    assign bus.res_dispense = res_dispense_q;
    assign bus.res_change   = res_change_q;
    assign bus.res_error    = res_error_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: doc/vending_panel_arbiter.md
Name: vending_panel_arbiter

Overview:
- Shares the single vending machine datapath between two user panels, P0 (front keypad) and P1 (remote kiosk).
- Grants session ownership to one panel per transaction and forwards only that panel's coin, item_sel and cancel to the machine.
- Rejects the other panel's coins while a session is active and watches the machine's state output to detect session end.
- Forces a refund (cancel) when the owner is idle for too long.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in an active session before a forced cancel.
- CNT_W, 10: inactivity counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_coin / p1_coin  in  2  panel coin pulse (00 none, 01=5, 10=10, 11=20)
- p0_item_sel / p1_item_sel  in  2  panel item select (00 none)
- p0_cancel / p1_cancel  in  1  panel cancel
- vm_state  in  3  machine state_out (000 IDLE, 001 ACCUM, 010 SELECT, 011 DISPENSE, 100 CHANGE, 101 ERROR)
- vm_dispense  in  2  machine dispense output
- vm_change  in  8  machine change output
- vm_error  in  1  machine error output
- vm_coin  out  2  registered coin to machine
- vm_item_sel  out  2  registered item select to machine
- vm_cancel  out  1  registered cancel to machine
- owner  out  2  one-hot current owner (01=P0, 10=P1, 00 none)
- p0_reject / p1_reject  out  1  one-cycle pulse: that panel's coin was refused
- p0_done / p1_done  out  1  one-cycle pulse: that panel's session ended
- res_dispense  out  2  last non-zero vm_dispense seen in the session
- res_change  out  8  last non-zero vm_change seen in the session
- res_error  out  1  sticky: vm_error seen during the session
- timeout  out  1  sticky: session ended by forced cancel

Behaviour:
- Reset (rst_n low, async): all outputs 0, state ARB_IDLE, priority pointer = P0, counter 0.
- All vm_* outputs are registered. They are 0 in any cycle not driven as described below.

States:
- ARB_IDLE:
  - Requester = panel with coin != 00.
  - One requester: it wins.
  - Both: the pointer panel wins and the loser gets a reject pulse next cycle.
  - Winner's coin is captured. Next cycle: owner set, vm_coin = captured coin for exactly one cycle, res_* cleared, timeout cleared, counter cleared, go OWN.
  - Item_sel and cancel from either panel are ignored in ARB_IDLE.
- OWN:
  - vm_coin/vm_item_sel/vm_cancel = owner's inputs delayed one cycle (1-cycle latency).
  - Simultaneous owner coin+cancel are forwarded unchanged; the machine resolves priority.
  - Non-owner coin != 00: pulse its reject next cycle, never forwarded.
  - Counter clears on any owner coin != 00, item_sel != 00 or cancel; otherwise it increments.
  - Counter == TIMEOUT_CYCLES-1 (i.e. TIMEOUT_CYCLES consecutive inactive cycles): drive vm_cancel = 1 for one cycle, set timeout, go FINISH.
  - vm_state == 100 (CHANGE): go FINISH.
  - vm_state == 101 (ERROR): stay in OWN. The balance is retained by the machine, so the owner may reselect or cancel.
- FINISH:
  - Owner inputs are no longer forwarded. Any panel coin != 00 is rejected.
  - Wait for vm_state == 000. Then pulse the owner's done for one cycle, set owner = 00, set the pointer to the other panel, and go ARB_IDLE.
  - Panel inputs presented in that same cycle are rejected (coins) or ignored.

Result capture (OWN and FINISH):
- vm_dispense != 00 loads res_dispense.
- vm_change != 0 loads res_change.
- vm_error sets res_error.
- res_* and timeout hold until the next grant.

Invariants and reset:
- Pointer updates only on release, so back-to-back contention alternates.
- owner is never 11. The non-owner's done never pulses.
- rst_n asserted mid-session aborts immediately to the reset values. No cancel is issued; the machine is reset by its own reset.

Test Plan:
- Reset then P0 coin=10 (1 cycle) -> next cycle owner=01, vm_coin=10 for one cycle; p1_reject stays 0.
- P0 owns with vm_state stepping to 011 then 100 then 000, vm_dispense=01, vm_change=5 -> p0_done pulses once; res_dispense=01, res_change=5; owner=00.
- Both panels coin=01 in the same idle cycle after reset -> owner=01, p1_reject pulses. Repeat after release -> owner=10, p0_reject pulses.
- P1 owns, P0 coin=11 mid-session -> p0_reject pulses, vm_coin never shows P0's value. P1 item_sel=10 -> vm_item_sel=10 one cycle later.
- P0 owns; vm_state=101 with vm_error=1 -> owner stays 01, res_error=1. Then P0 cancel -> vm_cancel=1, vm_state 100 then 000 -> p0_done pulses.
- P0 owns, no input for TIMEOUT_CYCLES (set to 8) -> vm_cancel pulses once, timeout=1. Reset asserted during FINISH -> all outputs 0 immediately.
